// File: rtl/mips_pkg.sv
// Shared MIPS memory-access decode: opcodes, load/store type enums and decoders.
package mips_pkg;

  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SB  = 6'b101000;

  typedef enum logic [2:0] {LD_NONE, LD_W, LD_B, LD_BU, LD_H, LD_HU} ld_type_e;
  typedef enum logic [1:0] {ST_NONE, ST_W, ST_H, ST_B} st_type_e;

  function automatic ld_type_e decode_ld(input logic [5:0] op);
    unique case (op)
      OP_LW:   return LD_W;
      OP_LB:   return LD_B;
      OP_LBU:  return LD_BU;
      OP_LH:   return LD_H;
      OP_LHU:  return LD_HU;
      default: return LD_NONE;
    endcase
  endfunction

  function automatic st_type_e decode_st(input logic [5:0] op);
    unique case (op)
      OP_SW:   return ST_W;
      OP_SH:   return ST_H;
      OP_SB:   return ST_B;
      default: return ST_NONE;
    endcase
  endfunction

endpackage

// File: rtl/dm_ext.sv
// Combinational load extender: selects the byte/half from a memory word, extends it
// and flags misaligned loads (result forced to 0 on misalignment or non-load).
module dm_ext
  import mips_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  addr_lo_i,
  input  ld_type_e    ld_type_i,
  output logic [31:0] data_o,
  output logic        misalign_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word_i[8*addr_lo_i +: 8];
    half_sel = addr_lo_i[1] ? word_i[31:16] : word_i[15:0];
  end

  always_comb begin
    data_o     = '0;
    misalign_o = 1'b0;
    unique case (ld_type_i)
      LD_W: begin
        misalign_o = (addr_lo_i != 2'b00);
        data_o     = misalign_o ? '0 : word_i;
      end
      LD_B:  data_o = {{24{byte_sel[7]}}, byte_sel};
      LD_BU: data_o = {24'h0, byte_sel};
      LD_H: begin
        misalign_o = addr_lo_i[0];
        data_o     = misalign_o ? '0 : {{16{half_sel[15]}}, half_sel};
      end
      LD_HU: begin
        misalign_o = addr_lo_i[0];
        data_o     = misalign_o ? '0 : {16'h0, half_sel};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MIPS M stage: word-organised data memory, store lane merge, load extension and the
// MEM/WB pipeline register. Define DM_WRITE_LOG_EN to print every committed store.
module mem_wb_stage
  import mips_pkg::*;
#(
  parameter int unsigned DM_WORDS = 1024,
  parameter int unsigned DM_AW    = 10
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] IR_M,
  input  logic [31:0] PC4_M,
  input  logic [31:0] AO_M,
  input  logic [31:0] RT_M,
  output logic [31:0] IR_W,
  output logic [31:0] PC4_W,
  output logic [31:0] AO_W,
  output logic [31:0] DR_W,
  output logic        AdEL_W,
  output logic        AdES_W
);

  localparam logic [31:0] DmBytes = 32'(4 * DM_WORDS);

  logic [31:0] mem_q [DM_WORDS];

  ld_type_e    ld_type;
  st_type_e    st_type;
  logic        in_range;
  logic [DM_AW-1:0] idx;
  logic [31:0] cur_word, rd_word, ext_data, wdata, merged;
  logic [3:0]  be;
  logic        ld_misalign, st_misalign, st_we;

  logic [31:0] ir_w_q, pc4_w_q, ao_w_q, dr_w_q;
  logic        adel_w_q, ades_w_q;

  always_comb begin
    ld_type  = decode_ld(IR_M[31:26]);
    st_type  = decode_st(IR_M[31:26]);
    in_range = (AO_M < DmBytes);
    idx      = AO_M[DM_AW+1:2];
    cur_word = mem_q[idx];
    rd_word  = in_range ? cur_word : '0;
  end

  dm_ext u_dm_ext (
    .word_i     (rd_word),
    .addr_lo_i  (AO_M[1:0]),
    .ld_type_i  (ld_type),
    .data_o     (ext_data),
    .misalign_o (ld_misalign)
  );

  // Store data is replicated across lanes; byte enables pick which lanes land.
  always_comb begin
    be          = 4'b0000;
    wdata       = RT_M;
    st_misalign = 1'b0;
    unique case (st_type)
      ST_W: begin
        be          = 4'b1111;
        st_misalign = (AO_M[1:0] != 2'b00);
      end
      ST_H: begin
        be          = AO_M[1] ? 4'b1100 : 4'b0011;
        wdata       = {2{RT_M[15:0]}};
        st_misalign = AO_M[0];
      end
      ST_B: begin
        be    = 4'b0001 << AO_M[1:0];
        wdata = {4{RT_M[7:0]}};
      end
      default: ;
    endcase
    st_we = (st_type != ST_NONE) && !st_misalign && in_range;
    for (int b = 0; b < 4; b++) begin
      merged[8*b +: 8] = be[b] ? wdata[8*b +: 8] : cur_word[8*b +: 8];
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int unsigned i = 0; i < DM_WORDS; i++) begin
        mem_q[i] <= '0;
      end
    end else if (st_we) begin
      mem_q[idx] <= merged;
    end
  end

`ifdef DM_WRITE_LOG_EN
  always_ff @(posedge Clk) begin
    if (!Reset && st_we) begin
      $display("@%h: *%h <= %h", PC4_M - 32'd4, {AO_M[31:2], 2'b00}, merged);
    end
  end
`else
`endif

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      ir_w_q   <= '0;
      pc4_w_q  <= '0;
      ao_w_q   <= '0;
      dr_w_q   <= '0;
      adel_w_q <= 1'b0;
      ades_w_q <= 1'b0;
    end else begin
      ir_w_q   <= IR_M;
      pc4_w_q  <= PC4_M;
      ao_w_q   <= AO_M;
      dr_w_q   <= ext_data;
      adel_w_q <= ld_misalign;
      ades_w_q <= st_misalign;
    end
  end

  assign IR_W   = ir_w_q;
  assign PC4_W  = pc4_w_q;
  assign AO_W   = ao_w_q;
  assign DR_W   = dr_w_q;
  assign AdEL_W = adel_w_q;
  assign AdES_W = ades_w_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed-vector bench for mem_wb_stage with hand-computed expected values.
module tb_mem_wb_stage;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [31:0] IR_M, PC4_M, AO_M, RT_M;
  logic [31:0] IR_W, PC4_W, AO_W, DR_W;
  logic        AdEL_W, AdES_W;

  int n_checks = 0;
  int n_fail   = 0;

  mem_wb_stage dut (
    .Clk    (Clk),
    .Reset  (Reset),
    .IR_M   (IR_M),
    .PC4_M  (PC4_M),
    .AO_M   (AO_M),
    .RT_M   (RT_M),
    .IR_W   (IR_W),
    .PC4_W  (PC4_W),
    .AO_W   (AO_W),
    .DR_W   (DR_W),
    .AdEL_W (AdEL_W),
    .AdES_W (AdES_W)
  );

  always #5 Clk = ~Clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [31:0] mk_ir(input logic [5:0] op);
    return {op, 5'd0, 5'd8, 16'h0000};
  endfunction

  // Drive one M-stage instruction and sample W outputs 1 time unit after the edge.
  task automatic step(input logic [5:0] op, input logic [31:0] pc4, input logic [31:0] ao,
                      input logic [31:0] rt);
    IR_M  = mk_ir(op);
    PC4_M = pc4;
    AO_M  = ao;
    RT_M  = rt;
    @(posedge Clk);
    #1;
  endtask

  initial begin
    Reset = 1'b1;
    IR_M  = '0;
    PC4_M = '0;
    AO_M  = '0;
    RT_M  = '0;
    #12;
    check_eq("rst_ir",   IR_W, 32'h0);
    check_eq("rst_dr",   DR_W, 32'h0);
    check_eq("rst_adel", {31'h0, AdEL_W}, 32'h0);
    @(negedge Clk);
    Reset = 1'b0;

    step(6'b101011, 32'h104, 32'h10, 32'h12345678);
    check_eq("sw_ir_w",  IR_W, mk_ir(6'b101011));
    check_eq("sw_pc4_w", PC4_W, 32'h104);
    check_eq("sw_ao_w",  AO_W, 32'h10);
    check_eq("sw_ades",  {31'h0, AdES_W}, 32'h0);
    check_eq("sw_dr",    DR_W, 32'h0);

    step(6'b100011, 32'h108, 32'h10, 32'h0);
    check_eq("lw_after_sw",  DR_W, 32'h12345678);
    check_eq("lw_adel",      {31'h0, AdEL_W}, 32'h0);

    step(6'b101000, 32'h10c, 32'h13, 32'h000000F0);
    check_eq("sb_ades", {31'h0, AdES_W}, 32'h0);
    step(6'b100000, 32'h110, 32'h13, 32'h0);
    check_eq("lb_13",   DR_W, 32'hFFFFFFF0);
    step(6'b100100, 32'h114, 32'h13, 32'h0);
    check_eq("lbu_13",  DR_W, 32'h000000F0);
    step(6'b100011, 32'h118, 32'h10, 32'h0);
    check_eq("lw_10_sb", DR_W, 32'hF0345678);

    step(6'b101001, 32'h11c, 32'h22, 32'h00008001);
    step(6'b100001, 32'h120, 32'h22, 32'h0);
    check_eq("lh_22",   DR_W, 32'hFFFF8001);
    step(6'b100101, 32'h124, 32'h22, 32'h0);
    check_eq("lhu_22",  DR_W, 32'h00008001);
    step(6'b100011, 32'h128, 32'h20, 32'h0);
    check_eq("lw_20_sh", DR_W, 32'h80010000);

    step(6'b101011, 32'h12c, 32'h11, 32'hDEADBEEF);
    check_eq("sw_mis_ades", {31'h0, AdES_W}, 32'h1);
    step(6'b100011, 32'h130, 32'h10, 32'h0);
    check_eq("lw_10_unch", DR_W, 32'hF0345678);
    check_eq("ades_clear", {31'h0, AdES_W}, 32'h0);

    step(6'b100001, 32'h134, 32'h21, 32'h0);
    check_eq("lh_mis_adel", {31'h0, AdEL_W}, 32'h1);
    check_eq("lh_mis_dr",   DR_W, 32'h0);

    // 0x1010 aliases word 0x10 in the index bits; the range check must block it.
    step(6'b101011, 32'h138, 32'h1010, 32'hCAFEBABE);
    check_eq("sw_oor_ades", {31'h0, AdES_W}, 32'h0);
    step(6'b100011, 32'h13c, 32'h10, 32'h0);
    check_eq("lw_10_oor", DR_W, 32'hF0345678);
    step(6'b100011, 32'h140, 32'h1010, 32'h0);
    check_eq("lw_oor_dr",   DR_W, 32'h0);
    check_eq("lw_oor_adel", {31'h0, AdEL_W}, 32'h0);

    IR_M = 32'h0; PC4_M = 32'h200; AO_M = 32'h55; RT_M = 32'h77;
    @(posedge Clk); #1;
    check_eq("nop_ir_w",  IR_W, 32'h0);
    check_eq("nop_pc4_w", PC4_W, 32'h200);
    check_eq("nop_ao_w",  AO_W, 32'h55);
    check_eq("nop_dr",    DR_W, 32'h0);

    IR_M = 32'h00851021; PC4_M = 32'h204; AO_M = 32'h10; RT_M = 32'h0;
    @(posedge Clk); #1;
    check_eq("addu_ir_w", IR_W, 32'h00851021);
    check_eq("addu_dr",   DR_W, 32'h0);
    check_eq("addu_flags", {30'h0, AdEL_W, AdES_W}, 32'h0);

    step(6'b100011, 32'h208, 32'h10, 32'h0);
    check_eq("lw_pre_rst", DR_W, 32'hF0345678);
    #3;
    Reset = 1'b1;
    #1;
    check_eq("arst_dr",  DR_W, 32'h0);
    check_eq("arst_ir",  IR_W, 32'h0);
    check_eq("arst_pc4", PC4_W, 32'h0);
    check_eq("arst_ao",  AO_W, 32'h0);
    @(posedge Clk); #1;
    Reset = 1'b0;
    step(6'b100011, 32'h20c, 32'h10, 32'h0);
    check_eq("lw_post_rst", DR_W, 32'h0);
    step(6'b100011, 32'h210, 32'h20, 32'h0);
    check_eq("lw20_post_rst", DR_W, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
